// File: rtl/csr_bank_pkg.sv
// csr_bank_pkg
// Shared definitions for the machine-mode CSR bank:
//   - csr_ops      : read-modify-write operation encoding driven by the csri unit
//   - CSR_*        : 12-bit CSR addresses handled by csr_bank
//   - MCI_*_BIT    : implemented bit positions inside mcountinhibit
//   - csr_apply_op : computes the value a CSR takes after an operation
package csr_bank_pkg;

   typedef enum logic [1:0] {
      CSR_OP_NONE  = 2'd0,   // read only
      CSR_OP_WRITE = 2'd1,
      CSR_OP_SET   = 2'd2,
      CSR_OP_CLEAR = 2'd3
   } csr_ops;

   typedef logic [11:0] csr_addr_t;

   localparam csr_addr_t CSR_MCYCLE        = 12'hB00;
   localparam csr_addr_t CSR_MCYCLEH       = 12'hB80;
   localparam csr_addr_t CSR_MINSTRET      = 12'hB02;
   localparam csr_addr_t CSR_MINSTRETH     = 12'hB82;
   localparam csr_addr_t CSR_MCOUNTINHIBIT = 12'h320;
   localparam csr_addr_t CSR_CYCLE         = 12'hC00;
   localparam csr_addr_t CSR_CYCLEH        = 12'hC80;
   localparam csr_addr_t CSR_INSTRET       = 12'hC02;
   localparam csr_addr_t CSR_INSTRETH      = 12'hC82;
   localparam csr_addr_t CSR_SCRATCH_BASE  = 12'h7C0;

   localparam int MCI_CY_BIT = 0;
   localparam int MCI_IR_BIT = 2;

   // New CSR value for a given op; CSR_OP_NONE leaves the value as it was.
   function automatic logic [31:0] csr_apply_op(input csr_ops      op,
                                                input logic [31:0] old_val,
                                                input logic [31:0] wdata);
      logic [31:0] res;
      case (op)
         CSR_OP_WRITE: res = wdata;
         CSR_OP_SET:   res = old_val | wdata;
         CSR_OP_CLEAR: res = old_val & ~wdata;
         default:      res = old_val;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/csr_bank_if.sv
// csr_bank_if
// Request/response bundle between the csri unit (master) and csr_bank (slave).
//   csr_valid_i   request strobe, always accepted
//   csr_op_i      csr_ops operation
//   csr_addr_i    12-bit CSR address
//   csr_wdata_i   32-bit operand
//   csr_rvalid_o  response valid, one cycle after the request
//   csr_rdata_o   old CSR value (0 when illegal)
//   csr_illegal_o access illegal, qualified by csr_rvalid_o
interface csr_bank_if;
   import csr_bank_pkg::*;

   logic        csr_valid_i;
   csr_ops      csr_op_i;
   logic [11:0] csr_addr_i;
   logic [31:0] csr_wdata_i;
   logic        csr_rvalid_o;
   logic [31:0] csr_rdata_o;
   logic        csr_illegal_o;

   modport master (
      output csr_valid_i, csr_op_i, csr_addr_i, csr_wdata_i,
      input  csr_rvalid_o, csr_rdata_o, csr_illegal_o
   );

   modport slave (
      input  csr_valid_i, csr_op_i, csr_addr_i, csr_wdata_i,
      output csr_rvalid_o, csr_rdata_o, csr_illegal_o
   );
endinterface

// File: rtl/csr_counter.sv
// csr_counter
// CNT_WIDTH-bit free-running counter with 32-bit half writes.
//   clk, reset_n  clock / asynchronous active-low reset
//   inc_en        count up by one this cycle
//   wr_lo, wr_hi  replace bits [31:0] / [CNT_WIDTH-1:32] with wdata
//   wdata         write data; bits above CNT_WIDTH-32 of a high write are dropped
//   value         current count
// Any write in a cycle suppresses that cycle's increment, even when only the
// other half is written.
module csr_counter #(
   parameter int CNT_WIDTH = 64
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 inc_en,
   input  logic                 wr_lo,
   input  logic                 wr_hi,
   input  logic [31:0]          wdata,
   output logic [CNT_WIDTH-1:0] value
);

   logic [CNT_WIDTH-1:0] cnt_reg;
   logic [CNT_WIDTH-1:0] cnt_next;

   always_comb begin
      cnt_next = cnt_reg;
      if (wr_lo || wr_hi) begin
         if (wr_lo) cnt_next[31:0] = wdata;
         if (wr_hi) cnt_next[CNT_WIDTH-1:32] = wdata[CNT_WIDTH-33:0];
      end else if (inc_en) begin
         cnt_next = cnt_reg + 1'b1;   // wraps modulo 2^CNT_WIDTH
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cnt_reg <= '0;
      else          cnt_reg <= cnt_next;
   end

   assign value = cnt_reg;

endmodule

// File: rtl/csr_bank.sv
// csr_bank
// Machine-mode CSR bank: mcycle/minstret counters with user read-only shadows,
// mcountinhibit and NUM_SCRATCH scratch registers at 0x7C0.
//   clk, reset_n  clock / asynchronous active-low reset
//   instret_i     one-cycle pulse per retired instruction
//   bus           csr_bank_if.slave request/response port
// Responses are registered: old value and illegal flag appear the cycle after
// the request. Illegal accesses change no state and return 0.
// Optional feature macro: CSR_BANK_INSTRET_EN (implements minstret/instret;
// when undefined those addresses read 0, writes are discarded and instret_i
// is ignored).
module csr_bank
   import csr_bank_pkg::*;
#(
   parameter int NUM_SCRATCH = 4,
   parameter int CNT_WIDTH   = 64
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       instret_i,
   csr_bank_if.slave  bus
);

   logic [CNT_WIDTH-1:0] mcycle_val;
   logic [63:0]          mcycle_ext;
   logic [63:0]          minstret_ext;
   logic                 mci_cy_reg;
   logic [31:0]          mci_read;
   logic [31:0]          scratch_reg [NUM_SCRATCH];
   logic [31:0]          scratch_rd;
   logic [3:0]           scratch_idx;
   logic                 scratch_hit;
   logic [NUM_SCRATCH-1:0] wr_scratch;

   logic                 mapped;
   logic                 read_only;
   logic                 legal;
   logic                 do_write;
   logic [31:0]          old_val;
   logic [31:0]          new_val;
   logic                 wr_mcycle_lo;
   logic                 wr_mcycle_hi;
   logic                 wr_mci;

   logic                 rvalid_reg;
   logic [31:0]          rdata_reg;
   logic                 illegal_reg;

   // ---------------------------------------------------------------- decode
   assign scratch_idx = bus.csr_addr_i[3:0];
   assign scratch_hit = (bus.csr_addr_i[11:4] == CSR_SCRATCH_BASE[11:4]) &&
                        ({28'd0, scratch_idx} < 32'(NUM_SCRATCH));

   // Explicit mux keeps the read index inside the implemented range.
   always_comb begin
      scratch_rd = '0;
      for (int i = 0; i < NUM_SCRATCH; i++) begin
         if (scratch_idx == i[3:0]) scratch_rd = scratch_reg[i];
      end
   end

   // High halves read zero-extended from CNT_WIDTH.
   assign mcycle_ext = 64'(mcycle_val);

   always_comb begin
      mapped    = 1'b1;
      read_only = 1'b0;
      old_val   = '0;
      case (bus.csr_addr_i)
         CSR_MCYCLE:        old_val = mcycle_ext[31:0];
         CSR_MCYCLEH:       old_val = mcycle_ext[63:32];
         CSR_MINSTRET:      old_val = minstret_ext[31:0];
         CSR_MINSTRETH:     old_val = minstret_ext[63:32];
         CSR_MCOUNTINHIBIT: old_val = mci_read;
         CSR_CYCLE: begin
            read_only = 1'b1;
            old_val   = mcycle_ext[31:0];
         end
         CSR_CYCLEH: begin
            read_only = 1'b1;
            old_val   = mcycle_ext[63:32];
         end
         CSR_INSTRET: begin
            read_only = 1'b1;
            old_val   = minstret_ext[31:0];
         end
         CSR_INSTRETH: begin
            read_only = 1'b1;
            old_val   = minstret_ext[63:32];
         end
         default: begin
            if (scratch_hit) old_val = scratch_rd;
            else             mapped  = 1'b0;
         end
      endcase
   end

   // Set/clear of a read-only CSR with a zero mask is a plain read.
   always_comb begin
      legal = mapped;
      if (read_only) begin
         if (bus.csr_op_i == CSR_OP_WRITE) legal = 1'b0;
         if ((bus.csr_op_i == CSR_OP_SET || bus.csr_op_i == CSR_OP_CLEAR) &&
             (bus.csr_wdata_i != 32'd0)) legal = 1'b0;
      end
   end

   assign do_write = bus.csr_valid_i && legal && !read_only &&
                     (bus.csr_op_i != CSR_OP_NONE);
   assign new_val  = csr_apply_op(bus.csr_op_i, old_val, bus.csr_wdata_i);

   assign wr_mcycle_lo = do_write && (bus.csr_addr_i == CSR_MCYCLE);
   assign wr_mcycle_hi = do_write && (bus.csr_addr_i == CSR_MCYCLEH);
   assign wr_mci       = do_write && (bus.csr_addr_i == CSR_MCOUNTINHIBIT);

   // -------------------------------------------------------------- counters
   csr_counter #(.CNT_WIDTH(CNT_WIDTH)) u_mcycle (
      .clk     (clk),
      .reset_n (reset_n),
      .inc_en  (!mci_cy_reg),
      .wr_lo   (wr_mcycle_lo),
      .wr_hi   (wr_mcycle_hi),
      .wdata   (new_val),
      .value   (mcycle_val)
   );

`ifdef CSR_BANK_INSTRET_EN
   logic [CNT_WIDTH-1:0] minstret_val;
   logic                 mci_ir_reg;
   logic                 wr_minstret_lo;
   logic                 wr_minstret_hi;

   assign wr_minstret_lo = do_write && (bus.csr_addr_i == CSR_MINSTRET);
   assign wr_minstret_hi = do_write && (bus.csr_addr_i == CSR_MINSTRETH);

   csr_counter #(.CNT_WIDTH(CNT_WIDTH)) u_minstret (
      .clk     (clk),
      .reset_n (reset_n),
      .inc_en  (instret_i && !mci_ir_reg),
      .wr_lo   (wr_minstret_lo),
      .wr_hi   (wr_minstret_hi),
      .wdata   (new_val),
      .value   (minstret_val)
   );

   assign minstret_ext = 64'(minstret_val);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)    mci_ir_reg <= 1'b0;
      else if (wr_mci) mci_ir_reg <= new_val[MCI_IR_BIT];
   end

   always_comb begin
      mci_read             = '0;
      mci_read[MCI_CY_BIT] = mci_cy_reg;
      mci_read[MCI_IR_BIT] = mci_ir_reg;
   end
`else
   logic instret_unused;

   // No minstret storage in this configuration: reads return 0, writes are discarded.
   assign instret_unused = instret_i;
   assign minstret_ext   = '0;

   always_comb begin
      mci_read             = '0;
      mci_read[MCI_CY_BIT] = mci_cy_reg;
   end
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)    mci_cy_reg <= 1'b0;
      else if (wr_mci) mci_cy_reg <= new_val[MCI_CY_BIT];
   end

   // --------------------------------------------------------------- scratch
   for (genvar gi = 0; gi < NUM_SCRATCH; gi++) begin : g_scratch
      assign wr_scratch[gi] = do_write && scratch_hit && (scratch_idx == 4'(gi));

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n)            scratch_reg[gi] <= '0;
         else if (wr_scratch[gi]) scratch_reg[gi] <= new_val;
      end
   end

   // -------------------------------------------------------------- response
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rvalid_reg  <= 1'b0;
         rdata_reg   <= '0;
         illegal_reg <= 1'b0;
      end else begin
         rvalid_reg  <= bus.csr_valid_i;
         rdata_reg   <= (bus.csr_valid_i && legal) ? old_val : 32'd0;
         illegal_reg <= bus.csr_valid_i && !legal;
      end
   end

   assign bus.csr_rvalid_o  = rvalid_reg;
   assign bus.csr_rdata_o   = rdata_reg;
   assign bus.csr_illegal_o = illegal_reg;

endmodule

// File: tb/tb_csr_bank.sv
// tb_csr_bank
// Self-checking bench for csr_bank: a table of back-to-back accesses with
// hand-computed results, plus hand-written sequences for counter timing,
// wrap, counter inhibit and reset in the middle of a request.
// Follows CSR_BANK_INSTRET_EN in the same way as the design.
module tb_csr_bank;
   import csr_bank_pkg::*;

`ifdef CSR_BANK_INSTRET_EN
   localparam logic [31:0] INH_ALL = 32'h5;
   localparam logic [31:0] IR_ONE  = 32'h1;
`else
   localparam logic [31:0] INH_ALL = 32'h1;
   localparam logic [31:0] IR_ONE  = 32'h0;
`endif

   typedef struct {
      csr_ops      op;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_illegal;
   } vec_t;

   localparam int NVEC = 23;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   logic instret = 1'b0;
   int   checks   = 0;
   int   failures = 0;
   vec_t vecs [NVEC];

   csr_bank_if bus ();

   csr_bank #(.NUM_SCRATCH(4), .CNT_WIDTH(64)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .instret_i (instret),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   // Drives one request (caller is just after a falling edge) and returns the
   // response sampled at the next falling edge. Leaves csr_valid_i high so
   // consecutive calls are back-to-back.
   task automatic req(input csr_ops op, input logic [11:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic illegal);
      bus.csr_valid_i = 1'b1;
      bus.csr_op_i    = op;
      bus.csr_addr_i  = addr;
      bus.csr_wdata_i = wdata;
      @(negedge clk);
      check($sformatf("rvalid_%03h", addr), 32'(bus.csr_rvalid_o), 32'd1);
      rdata   = bus.csr_rdata_o;
      illegal = bus.csr_illegal_o;
      $display("txn op=%s addr=0x%03h wdata=0x%08h rdata=0x%08h illegal=%0d",
               op.name(), addr, wdata, rdata, illegal);
   endtask

   // One cycle with no request; the following response slot must be empty.
   task automatic idle(input string name);
      bus.csr_valid_i = 1'b0;
      bus.csr_op_i    = CSR_OP_NONE;
      @(negedge clk);
      check({name, "_rvalid"},  32'(bus.csr_rvalid_o),  32'd0);
      check({name, "_rdata"},   bus.csr_rdata_o,        32'd0);
      check({name, "_illegal"}, 32'(bus.csr_illegal_o), 32'd0);
   endtask

   task automatic pulse_instret(input int n);
      bus.csr_valid_i = 1'b0;
      for (int k = 0; k < n; k++) begin
         instret = 1'b1;
         @(negedge clk);
         instret = 1'b0;
         @(negedge clk);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] rd;
      logic        il;
      logic [31:0] base;

      vecs[0]  = '{CSR_OP_WRITE, 12'h7C0, 32'hDEADBEEF, 32'h0,        1'b0};
      vecs[1]  = '{CSR_OP_NONE,  12'h7C0, 32'h0,        32'hDEADBEEF, 1'b0};
      vecs[2]  = '{CSR_OP_CLEAR, 12'h7C0, 32'hFFFF0000, 32'hDEADBEEF, 1'b0};
      vecs[3]  = '{CSR_OP_NONE,  12'h7C0, 32'h0,        32'h0000BEEF, 1'b0};
      vecs[4]  = '{CSR_OP_WRITE, 12'h7C1, 32'hF0,       32'h0,        1'b0};
      vecs[5]  = '{CSR_OP_SET,   12'h7C1, 32'h0F,       32'hF0,       1'b0};
      vecs[6]  = '{CSR_OP_NONE,  12'h7C1, 32'h0,        32'hFF,       1'b0};
      vecs[7]  = '{CSR_OP_WRITE, 12'h7C3, 32'hA5A5,     32'h0,        1'b0};
      vecs[8]  = '{CSR_OP_NONE,  12'h7C3, 32'h0,        32'hA5A5,     1'b0};
      vecs[9]  = '{CSR_OP_WRITE, 12'h7C4, 32'h1,        32'h0,        1'b1};
      vecs[10] = '{CSR_OP_NONE,  12'h7C4, 32'h0,        32'h0,        1'b1};
      vecs[11] = '{CSR_OP_NONE,  12'h123, 32'h0,        32'h0,        1'b1};
      vecs[12] = '{CSR_OP_WRITE, 12'hC00, 32'h1,        32'h0,        1'b1};
      vecs[13] = '{CSR_OP_CLEAR, 12'hC80, 32'h1,        32'h0,        1'b1};
      vecs[14] = '{CSR_OP_SET,   12'hC02, 32'h1,        32'h0,        1'b1};
      vecs[15] = '{CSR_OP_WRITE, 12'h320, 32'hFFFFFFFF, 32'h0,        1'b0};
      vecs[16] = '{CSR_OP_NONE,  12'h320, 32'h0,        INH_ALL,      1'b0};
      vecs[17] = '{CSR_OP_WRITE, 12'h320, 32'h0,        INH_ALL,      1'b0};
      vecs[18] = '{CSR_OP_NONE,  12'h320, 32'h0,        32'h0,        1'b0};
      vecs[19] = '{CSR_OP_WRITE, 12'hB82, 32'h0,        32'h0,        1'b0};
      vecs[20] = '{CSR_OP_NONE,  12'hB82, 32'h0,        32'h0,        1'b0};
      vecs[21] = '{CSR_OP_NONE,  12'hC82, 32'h0,        32'h0,        1'b0};
      vecs[22] = '{CSR_OP_NONE,  12'h7C0, 32'h0,        32'h0000BEEF, 1'b0};

      bus.csr_valid_i = 1'b0;
      bus.csr_op_i    = CSR_OP_NONE;
      bus.csr_addr_i  = '0;
      bus.csr_wdata_i = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_rvalid",  32'(bus.csr_rvalid_o),  32'd0);
      check("rst_rdata",   bus.csr_rdata_o,        32'd0);
      check("rst_illegal", 32'(bus.csr_illegal_o), 32'd0);
      reset_n = 1'b1;

      // First counting edge is the first edge after release
      req(CSR_OP_NONE, 12'hB00, 32'h0, rd, il);
      check("mcycle_first", rd, 32'd0);
      check("mcycle_first_ill", 32'(il), 32'd0);
      idle("gap0");
      req(CSR_OP_NONE, 12'hB00, 32'h0, rd, il);
      check("mcycle_second", rd, 32'd2);
      check("mcycle_second_ill", 32'(il), 32'd0);

      // Low-half wrap; writing the high half drops that cycle's increment
      req(CSR_OP_WRITE, 12'hB00, 32'hFFFFFFFF, rd, il);
      check("wr_mcycle_ill", 32'(il), 32'd0);
      req(CSR_OP_WRITE, 12'hB80, 32'h0, rd, il);
      check("wr_mcycleh_old", rd, 32'd0);
      req(CSR_OP_NONE, 12'hB00, 32'h0, rd, il);
      check("wrap_lo_ff", rd, 32'hFFFFFFFF);
      req(CSR_OP_NONE, 12'hB00, 32'h0, rd, il);
      check("wrap_lo_0", rd, 32'h0);
      req(CSR_OP_NONE, 12'hB80, 32'h0, rd, il);
      check("wrap_hi_1", rd, 32'h1);

      // Table of back-to-back accesses
      for (int i = 0; i < NVEC; i++) begin
         req(vecs[i].op, vecs[i].addr, vecs[i].wdata, rd, il);
         check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
         check($sformatf("vec%0d_illegal", i), 32'(il), 32'(vecs[i].exp_illegal));
      end
      idle("gap1");

      // Illegal write to cycle leaves mcycle running undisturbed
      req(CSR_OP_NONE, 12'hB00, 32'h0, base, il);
      req(CSR_OP_WRITE, 12'hC00, 32'h1, rd, il);
      check("ro_wr_rdata", rd, 32'h0);
      check("ro_wr_ill", 32'(il), 32'd1);
      req(CSR_OP_NONE, 12'hB00, 32'h0, rd, il);
      check("ro_wr_cycle_kept", rd, base + 32'd2);
      req(CSR_OP_SET, 12'hC00, 32'h0, rd, il);
      check("ro_set0_rdata", rd, base + 32'd3);
      check("ro_set0_ill", 32'(il), 32'd0);
      req(CSR_OP_CLEAR, 12'hC80, 32'h0, rd, il);
      check("ro_clr0_rdata", rd, 32'h1);
      check("ro_clr0_ill", 32'(il), 32'd0);

      // Counter inhibit
      req(CSR_OP_WRITE, 12'h320, 32'h5, rd, il);
      check("inh_wr_old", rd, 32'h0);
      req(CSR_OP_NONE, 12'hB00, 32'h0, base, il);
      pulse_instret(3);
      req(CSR_OP_NONE, 12'hB00, 32'h0, rd, il);
      check("inh_mcycle_frozen", rd, base);
      req(CSR_OP_NONE, 12'hB02, 32'h0, rd, il);
      check("inh_minstret_frozen", rd, 32'h0);
      req(CSR_OP_CLEAR, 12'h320, 32'h4, rd, il);
      check("inh_clr_old", rd, INH_ALL);
      pulse_instret(1);
      req(CSR_OP_NONE, 12'hB02, 32'h0, rd, il);
      check("inh_minstret_count", rd, IR_ONE);
      req(CSR_OP_NONE, 12'hC02, 32'h0, rd, il);
      check("inh_instret_shadow", rd, IR_ONE);
      req(CSR_OP_NONE, 12'hB00, 32'h0, rd, il);
      check("inh_mcycle_still", rd, base);
      req(CSR_OP_CLEAR, 12'h320, 32'h1, rd, il);
      check("inh_clr_cy_old", rd, 32'h1);

      // Reset asserted while a scratch write is being issued
      bus.csr_valid_i = 1'b1;
      bus.csr_op_i    = CSR_OP_WRITE;
      bus.csr_addr_i  = 12'h7C0;
      bus.csr_wdata_i = 32'h12345678;
      #2 reset_n = 1'b0;
      #1;
      check("midrst_rvalid", 32'(bus.csr_rvalid_o), 32'd0);
      check("midrst_rdata",  bus.csr_rdata_o,       32'd0);
      @(negedge clk);
      check("midrst_dropped", 32'(bus.csr_rvalid_o), 32'd0);
      bus.csr_valid_i = 1'b0;
      bus.csr_op_i    = CSR_OP_NONE;
      reset_n = 1'b1;
      req(CSR_OP_NONE, 12'hB00, 32'h0, rd, il);
      check("postrst_mcycle", rd, 32'h0);
      req(CSR_OP_NONE, 12'h7C0, 32'h0, rd, il);
      check("postrst_scratch0", rd, 32'h0);
      req(CSR_OP_NONE, 12'h7C1, 32'h0, rd, il);
      check("postrst_scratch1", rd, 32'h0);
      req(CSR_OP_NONE, 12'h320, 32'h0, rd, il);
      check("postrst_mci", rd, 32'h0);
      idle("gap2");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/csr_bank.md
# csr_bank

Parametrised machine-mode CSR bank for the RV32 core: performance counters (mcycle, minstret and their user read-only shadows), a counter-inhibit register and a configurable array of scratch registers. It sits beside the execute stage's csri unit. It performs write/set/clear read-modify-write operations from the csr_ops encoding and returns the old value one cycle after acceptance. Illegal accesses are flagged without any state change.

## Interface
- NUM_SCRATCH, 4: number of 32-bit scratch CSRs at 0x7C0+i; range 1..16
- CNT_WIDTH, 64: counter width; range 33..64; the high half is CNT_WIDTH-32 bits, zero-extended on read
- clk  in  1  core clock
- reset_n  in  1  reset; one clock, asynchronous and active-low
- csr_valid_i  in  1  request strobe; always accepted (no backpressure)
- csr_op_i  in  2  csr_ops: none=read only, write, set, clear
- csr_addr_i  in  12  CSR address
- csr_wdata_i  in  32  operand (rs1 value or zero-extended immediate)
- instret_i  in  1  one-cycle pulse per retired instruction
- csr_rvalid_o  out  1  response valid, one cycle after request
- csr_rdata_o  out  32  old CSR value; 0 when illegal
- csr_illegal_o  out  1  access illegal; qualified by csr_rvalid_o

## Operation
- Address map:
  - mcycle 0xB00 / mcycleh 0xB80 (RW)
  - minstret 0xB02 / minstreth 0xB82 (RW)
  - mcountinhibit 0x320 (RW; only bits 0 and 2 implemented, others read 0)
  - cycle 0xC00 / cycleh 0xC80 (RO)
  - instret 0xC02 / instreth 0xC82 (RO)
  - scratch 0x7C0..0x7C0+NUM_SCRATCH-1 (RW)
- New value per op:
  - write: wdata
  - set: old | wdata
  - clear: old & ~wdata
  - none: no write
- Illegal conditions:
  - unmapped address, or scratch index ≥ NUM_SCRATCH
  - op=write to an RO address
  - op=set/clear to an RO address with wdata≠0
- Legal no-write cases: set/clear with wdata=0 on an RO address; op none anywhere.
- Illegal access effects: no state change, rdata 0.
- mcycle increments every cycle unless mcountinhibit[0]=1.
- minstret increments on instret_i unless mcountinhibit[2]=1.
- Counter increments are modulo 2^CNT_WIDTH; all-ones wraps to 0.
- A write to a counter half replaces that half and keeps the other.
- Simultaneous software write and increment on the same counter: the write wins and the increment is dropped that cycle, whichever half is written.
- Writes to high-half bits above CNT_WIDTH-32 are discarded.

## Timing
- Request sampled at rising edge ending cycle T. State update lands at that same edge.
- csr_rvalid_o/csr_rdata_o/csr_illegal_o are registered and valid during T+1.
- rdata is the value held during T, before update and before that edge's increment.
- Back-to-back requests every cycle are supported; a request in T+1 observes the write from T.
- csr_rvalid_o=0 in any cycle following one with csr_valid_i=0. rdata and illegal are then 0.
- Reset (asynchronous, any time, including mid-request): all counters, scratch and mcountinhibit go to 0; all outputs go to 0. The pending response is lost.
- First counting edge is the first clk rising edge after reset_n deasserts. mcycle reads 0 in the cycle following deassertion.

## Configuration
- CSR_BANK_INSTRET_EN defined: minstret/instret implemented as above.
- CSR_BANK_INSTRET_EN undefined:
  - no minstret storage; instret_i ignored
  - 0xB02/0xB82 read 0; writes are legal and discarded
  - 0xC02/0xC82 read 0 with RO illegality rules unchanged
  - mcountinhibit[2] reads 0

## Structure
- Shared package additions:
  - csr address constants (typed localparams per CSR above)
  - scratch base 0x7C0
  - mcountinhibit bit indices
  - reuse the existing csr_ops enum for csr_op_i
- Sub-module csr_counter: parametrised CNT_WIDTH register with inc_en, wr_lo, wr_hi, wdata; write-over-increment priority. Instantiated for mcycle and, under the macro, minstret.

## Test plan
- After reset: read 0xB00 in T, then read 0xB00 in the cycle after its response (T+2) → first read returns 0; second returns 2. csr_illegal_o=0 on both.
- write 0xFFFFFFFF to 0xB00, then write 0 to 0xB80 with mcountinhibit=0 → next cycles read mcycle low wrapping 0xFFFFFFFF→0; mcycleh increments to 1.
- set 0x7C1 with wdata 0x0F after write 0xF0 → rdata 0xF0 on the set; following read returns 0xFF.
- write 0x1 to 0xC00 → csr_illegal_o=1, rdata 0, cycle unchanged. set 0xC00 with wdata 0 → legal; rdata is current cycle.
- set mcountinhibit=0x5, pulse instret_i 3 times → mcycle and minstret frozen. clear bit 2 → minstret counts the next pulse. With CSR_BANK_INSTRET_EN undefined → 0xB02 always reads 0.
- Assert reset_n low in the cycle a write to 0x7C0 is issued → response dropped; 0x7C0 reads 0 after release.
